// File: rtl/multicycle_alu.sv
// Multicycle integer ALU. Single-cycle arithmetic and logic ops, an iterative shift-add
// multiply and a restoring divide, with a valid/ready handshake on both sides.
module multicycle_alu #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [3:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] z
);
  // state | meaning
  // IDLE  | waiting for an operation, in_ready high
  // MUL   | one shift-add step per cycle
  // DIV   | one restoring-division step per cycle
  // DONE  | holding z and out_valid until out_ready
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1011;
  localparam logic [3:0] OP_MFHI = 4'b1101;
  localparam logic [3:0] OP_EQ   = 4'b1110;
  localparam logic [3:0] OP_NEQ  = 4'b1111;
  localparam int CW = $clog2(N);

  state_t          state;
  logic [2*N-1:0]  acc;   // MUL: {partial sum, multiplier}; DIV: {remainder, dividend/quotient}
  logic [N-1:0]    opnd;
  logic [N-1:0]    hi;
  logic [CW-1:0]   cnt;
  logic [N:0]      mul_sum;
  logic [N:0]      div_shift;
  logic [N:0]      div_diff;
  logic [2*N-1:0]  mul_next;
  logic [2*N-1:0]  div_next;
  logic [N-1:0]    single_z;

  assign in_ready = (state == IDLE) && !rst;

  assign mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : {(N+1){1'b0}});
  assign mul_next  = {mul_sum, acc[N-1:1]};
  assign div_shift = {acc[2*N-1:N], acc[N-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_next  = div_diff[N] ? {div_shift[N-1:0], acc[N-2:0], 1'b0}
                                 : {div_diff[N-1:0],  acc[N-2:0], 1'b1};

  always_comb begin
    single_z = '0;
    case (mode)
      OP_ADD:  single_z = x + y;
      OP_SUB:  single_z = x - y;
      OP_DIV:  single_z = '1;
      OP_AND:  single_z = x & y;
      OP_OR:   single_z = x | y;
      OP_XOR:  single_z = x ^ y;
      OP_NOR:  single_z = ~(x | y);
      OP_SLL:  single_z = (y >= N) ? '0 : (x << y);
      OP_SRL:  single_z = (y >= N) ? '0 : (x >> y);
      OP_SLT:  single_z = {{(N-1){1'b0}}, x < y};
      OP_MFHI: single_z = hi;
      OP_EQ:   single_z = {{(N-1){1'b0}}, x == y};
      OP_NEQ:  single_z = {{(N-1){1'b0}}, x != y};
      default: single_z = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      z         <= '0;
      hi        <= '0;
      acc       <= '0;
      opnd      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (mode == OP_MUL) begin
              acc   <= {{N{1'b0}}, y};
              opnd  <= x;
              cnt   <= CW'(N-1);
              state <= MUL;
            end else if (mode == OP_DIV && y != '0) begin
              acc   <= {{N{1'b0}}, x};
              opnd  <= y;
              cnt   <= CW'(N-1);
              state <= DIV;
            end else begin
              z         <= single_z;
              if (mode == OP_DIV) hi <= x;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        MUL: begin
          acc <= mul_next;
          if (cnt == '0) begin
            z         <= mul_next[N-1:0];
            hi        <= mul_next[2*N-1:N];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DIV: begin
          acc <= div_next;
          if (cnt == '0) begin
            z         <= div_next[N-1:0];
            hi        <= div_next[2*N-1:N];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: directed corner cases plus random ops
// checked against an arithmetic reference model, with random output backpressure.
module tb_multicycle_alu;
  localparam int N = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic [3:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] z;

  multicycle_alu #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .z(z)
  );

  typedef struct {
    logic [N-1:0] z;
    int           lat;
    int           acc;
    int           op;
  } exp_t;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  logic [N-1:0] hi_m;
  bit           bp_rand = 0;
  logic         prev_ov = 0;
  logic         prev_ordy = 0;
  logic         prev_rst = 1;
  logic [N-1:0] prev_z = '0;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bp_rand) begin
    #2;
    out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: plain arithmetic on 64-bit values.
  task automatic model(input logic [3:0] m, input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] r, output int lat);
    logic [63:0] p;
    lat = 1;
    r   = '0;
    case (m)
      4'd1:  r = a + b;
      4'd2:  r = a - b;
      4'd3:  begin p = 64'(a) * 64'(b); r = p[31:0]; hi_m = p[63:32]; lat = N + 1; end
      4'd4:  if (b == 0) begin r = '1; hi_m = a; end
             else begin r = a / b; hi_m = a % b; lat = N + 1; end
      4'd5:  r = a & b;
      4'd6:  r = a | b;
      4'd7:  r = a ^ b;
      4'd8:  r = ~(a | b);
      4'd9:  r = (b >= 32) ? '0 : a << b;
      4'd10: r = (b >= 32) ? '0 : a >> b;
      4'd11: r = (a < b) ? 1 : 0;
      4'd13: r = hi_m;
      4'd14: r = (a == b) ? 1 : 0;
      4'd15: r = (a != b) ? 1 : 0;
      default: r = '0;
    endcase
  endtask

  task automatic issue(input logic [3:0] m, input logic [N-1:0] a, input logic [N-1:0] b,
                       input bit push);
    exp_t e;
    int   waited;
    @(posedge clk); #1;
    in_valid = 1; mode = m; x = a; y = b; waited = 0;
    while (!in_ready && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready still %b after %0d cycles, expected 1", in_ready, waited);
      in_valid = 0;
      return;
    end
    if (push) begin
      model(m, a, b, e.z, e.lat);
      e.acc = cyc;
      e.op  = m;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 0; x = $urandom; y = $urandom; mode = 4'($urandom);
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || out_valid) && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 500) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  // Monitor: pops the scoreboard on each new result and checks DONE holding.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: out_valid 1 with z=%h, expected no result", z);
        end else begin
          e = sb.pop_front();
          chk($sformatf("z op=%0d", e.op), z, e.z);
          chk($sformatf("latency op=%0d", e.op), N'(cyc - e.acc), N'(e.lat));
        end
      end
      if (prev_ov && !prev_ordy && !prev_rst) begin
        chk("hold out_valid", {31'b0, out_valid}, 1);
        chk("hold z", z, prev_z);
        chk("hold in_ready", {31'b0, in_ready}, 0);
      end
    end
    prev_ov   = out_valid;
    prev_ordy = out_ready;
    prev_z    = z;
    prev_rst  = rst;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time %0t exceeded, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   m;
    logic [N-1:0] a, b;
    rst = 1; in_valid = 0; out_ready = 1; x = '0; y = '0; mode = '0; hi_m = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", {31'b0, in_ready}, 0);
    chk("reset out_valid", {31'b0, out_valid}, 0);
    chk("reset z", z, 0);
    rst = 0;
    #1;
    chk("in_ready after reset", {31'b0, in_ready}, 1);

    issue(4'b0001, 32'hFFFFFFFF, 32'h1, 1);
    issue(4'b0011, 32'h00010000, 32'h00010000, 1);
    issue(4'b1101, $urandom, $urandom, 1);
    issue(4'b0100, 32'd100, 32'd7, 1);
    issue(4'b1101, $urandom, $urandom, 1);
    issue(4'b0100, 32'd5, 32'd0, 1);
    issue(4'b1101, $urandom, $urandom, 1);
    issue(4'b1001, 32'h1, 32'd32, 1);
    issue(4'b1010, 32'h80000000, 32'd31, 1);
    issue(4'b1011, 32'h1, 32'hFFFFFFFF, 1);
    issue(4'b1100, $urandom, $urandom, 1);
    issue(4'b1111, 32'h5, 32'h5, 1);
    drain();

    // Backpressure on an ADD result; in_valid pulses while DONE must be ignored.
    @(posedge clk); #3;
    out_ready = 0;
    issue(4'b0001, 32'd3, 32'd4, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; mode = 4'b0001; x = $urandom; y = $urandom;
      chk("bp in_ready", {31'b0, in_ready}, 0);
      chk("bp out_valid", {31'b0, out_valid}, 1);
      chk("bp z", z, 32'd7);
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp release in_ready", {31'b0, in_ready}, 1);
    chk("bp release out_valid", {31'b0, out_valid}, 0);
    drain();

    bp_rand = 1;
    for (int i = 0; i < 60; i++) begin
      m = 4'($urandom_range(0, 15));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(0, 40);
        1: b = '0;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) b = a;
      issue(m, a, b, 1);
    end
    drain();
    bp_rand = 0;
    @(posedge clk); #3;
    out_ready = 1;

    // Reset in the middle of a long multiply discards it and clears hi.
    issue(4'b0011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("mid-reset in_ready", {31'b0, in_ready}, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid-reset out_valid", {31'b0, out_valid}, 0);
    chk("mid-reset z", z, 0);
    rst = 0;
    #1;
    chk("post-reset in_ready", {31'b0, in_ready}, 1);
    hi_m = '0;
    issue(4'b1101, $urandom, $urandom, 1);
    drain();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
